// File: rtl/combination_lock_param.sv
// -----------------------------------------------------------------------------
// combination_lock_param
//
// Parametrised combination lock. A NUM_DIGITS-long code is entered one
// DIGIT_W-bit digit per rising edge of Enter. A wrong digit is only remembered
// in a mismatch flag, and the attempt is judged after the last digit, so the
// lock never reveals which digit was wrong. MAX_FAILS consecutive bad attempts
// put the lock into a timed LOCKOUT of LOCKOUT_CYCLES clocks. While open, the
// code can be re-programmed through a shadow register that is only committed
// once every digit has been entered.
//
// Ports:
//   Clk      in   system clock, rising edge
//   Reset_n  in   asynchronous active-low reset
//   Enter    in   digit-entry button level (debounced, synchronised upstream)
//   Digit    in   digit value sampled on a press
//   Program  in   level, request code programming while OPEN (hold to stay)
//   Relock   in   level, close the lock from OPEN or abort programming
//   state    out  LOCKED=00, OPEN=01, PROG=10, LOCKOUT=11
//   Lock     out  4'b1111 while OPEN or PROG, else 4'b0000
//   Alarm    out  high exactly while in LOCKOUT
//   Fails    out  consecutive failed-attempt count
// -----------------------------------------------------------------------------
module combination_lock_param #(
    parameter int DIGIT_W        = 4,
    parameter int NUM_DIGITS     = 3,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 12'hD79,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic                             Clk,
    input  logic                             Reset_n,
    input  logic                             Enter,
    input  logic [DIGIT_W-1:0]               Digit,
    input  logic                             Program,
    input  logic                             Relock,
    output logic [1:0]                       state,
    output logic [3:0]                       Lock,
    output logic                             Alarm,
    output logic [$clog2(MAX_FAILS+1)-1:0]   Fails
);

    localparam int CODE_W = NUM_DIGITS * DIGIT_W;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TMR_W  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAILS);

    typedef enum logic [1:0] {
        ST_LOCKED  = 2'b00,
        ST_OPEN    = 2'b01,
        ST_PROG    = 2'b10,
        ST_LOCKOUT = 2'b11
    } state_t;

    // Digit 0 occupies the most-significant field of the code word.
    function automatic logic [DIGIT_W-1:0] get_digit(
        input logic [CODE_W-1:0] code,
        input logic [IDX_W-1:0]  idx
    );
        int lsb;
        lsb = (NUM_DIGITS - 1 - int'(idx)) * DIGIT_W;
        return code[lsb +: DIGIT_W];
    endfunction

    function automatic logic [CODE_W-1:0] set_digit(
        input logic [CODE_W-1:0]  code,
        input logic [IDX_W-1:0]   idx,
        input logic [DIGIT_W-1:0] dig
    );
        logic [CODE_W-1:0] res;
        int lsb;
        res = code;
        lsb = (NUM_DIGITS - 1 - int'(idx)) * DIGIT_W;
        res[lsb +: DIGIT_W] = dig;
        return res;
    endfunction

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                mism_q, mism_d;
    logic [FAIL_W-1:0]   fails_q, fails_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [CODE_W-1:0]   shadow_q, shadow_d;
    logic                enter_q;
    logic [3:0]          lock_q, lock_d;
    logic                alarm_q, alarm_d;

    logic                press_s;
    logic                digit_miss_s;
    logic [FAIL_W:0]     fails_inc_s;
    logic [CODE_W-1:0]   shadow_wr_s;

    // Rising-edge detect on Enter; a held button yields exactly one press.
    assign press_s      = Enter & ~enter_q;
    assign digit_miss_s = (Digit != get_digit(code_q, idx_q));
    // One bit wider than Fails so the increment cannot wrap before compare.
    assign fails_inc_s  = {1'b0, fails_q} + {{FAIL_W{1'b0}}, 1'b1};
    assign shadow_wr_s  = set_digit(shadow_q, idx_q, Digit);

    // Next-state and datapath decode for the lock FSM.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mism_d   = mism_q;
        fails_d  = fails_q;
        timer_d  = timer_q;
        code_d   = code_q;
        shadow_d = shadow_q;

        case (state_q)
            ST_LOCKED: begin
                if (press_s) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d  = {IDX_W{1'b0}};
                        mism_d = 1'b0;
                        if (!(mism_q || digit_miss_s)) begin
                            state_d = ST_OPEN;
                            fails_d = {FAIL_W{1'b0}};
                        end else if (fails_inc_s < (FAIL_W+1)'(MAX_FAILS)) begin
                            fails_d = fails_inc_s[FAIL_W-1:0];
                        end else begin
                            fails_d = FAIL_MAX;
                            state_d = ST_LOCKOUT;
                            timer_d = TMR_LOAD;
                        end
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        mism_d = mism_q | digit_miss_s;
                    end
                end else begin
                    state_d = ST_LOCKED;
                end
            end

            ST_OPEN: begin
                if (Relock) begin
                    state_d = ST_LOCKED;
                    idx_d   = {IDX_W{1'b0}};
                    mism_d  = 1'b0;
                end else if (Program) begin
                    state_d  = ST_PROG;
                    idx_d    = {IDX_W{1'b0}};
                    shadow_d = code_q;
                end else begin
                    state_d = ST_OPEN;
                end
            end

            ST_PROG: begin
                if (Relock) begin
                    state_d = ST_LOCKED;
                    idx_d   = {IDX_W{1'b0}};
                    mism_d  = 1'b0;
                end else if (!Program) begin
                    state_d = ST_OPEN;
                    idx_d   = {IDX_W{1'b0}};
                end else if (press_s) begin
                    shadow_d = shadow_wr_s;
                    if (idx_q == LAST_IDX) begin
                        code_d  = shadow_wr_s;
                        state_d = ST_LOCKED;
                        idx_d   = {IDX_W{1'b0}};
                        mism_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = ST_PROG;
                end
            end

            ST_LOCKOUT: begin
                idx_d = {IDX_W{1'b0}};
                // The exit edge is the one where the timer already reads 0,
                // which yields exactly LOCKOUT_CYCLES cycles in this state.
                if (timer_q == {TMR_W{1'b0}}) begin
                    state_d = ST_LOCKED;
                    fails_d = {FAIL_W{1'b0}};
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end

            default: begin
                state_d = ST_LOCKED;
                idx_d   = {IDX_W{1'b0}};
                mism_d  = 1'b0;
            end
        endcase
    end

    // Output decode from the next state so the outputs can be registered.
    always_comb begin
        lock_d  = 4'b0000;
        alarm_d = 1'b0;
        if ((state_d == ST_OPEN) || (state_d == ST_PROG)) begin
            lock_d = 4'b1111;
        end else begin
            lock_d = 4'b0000;
        end
        if (state_d == ST_LOCKOUT) begin
            alarm_d = 1'b1;
        end else begin
            alarm_d = 1'b0;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_LOCKED;
            idx_q    <= {IDX_W{1'b0}};
            mism_q   <= 1'b0;
            fails_q  <= {FAIL_W{1'b0}};
            timer_q  <= {TMR_W{1'b0}};
            code_q   <= DEFAULT_CODE;
            shadow_q <= {CODE_W{1'b0}};
            enter_q  <= 1'b0;
            lock_q   <= 4'b0000;
            alarm_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mism_q   <= mism_d;
            fails_q  <= fails_d;
            timer_q  <= timer_d;
            code_q   <= code_d;
            shadow_q <= shadow_d;
            enter_q  <= Enter;
            lock_q   <= lock_d;
            alarm_q  <= alarm_d;
        end
    end

    assign state = state_q;
    assign Lock  = lock_q;
    assign Alarm = alarm_q;
    assign Fails = fails_q;

endmodule

// File: tb/tb_combination_lock_param.sv
module tb_combination_lock_param;

    logic       clk;
    logic       rst_n;
    logic       enter;
    logic [3:0] digit;
    logic       prog;
    logic       relock;
    logic [1:0] st;
    logic [3:0] lock;
    logic       alarm;
    logic [1:0] fails;

    int total;
    int bad;

    combination_lock_param dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .Enter   (enter),
        .Digit   (digit),
        .Program (prog),
        .Relock  (relock),
        .state   (st),
        .Lock    (lock),
        .Alarm   (alarm),
        .Fails   (fails)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       e;
        logic [3:0] d;
        logic       p;
        logic       r;
        logic [1:0] st;
        logic [1:0] fl;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic e, logic [3:0] d, logic p, logic r,
                                logic [1:0] s, logic [1:0] f);
        vec_t v;
        v.e = e; v.d = d; v.p = p; v.r = r; v.st = s; v.fl = f;
        vecs.push_back(v);
    endfunction

    // One compare of all four outputs against a state/fails expectation.
    task automatic chk(input string name, input logic [1:0] es, input logic [1:0] ef);
        logic [3:0] el;
        logic       ea;
        el = ((es == 2'b01) || (es == 2'b10)) ? 4'b1111 : 4'b0000;
        ea = (es == 2'b11);
        total++;
        if ((st !== es) || (lock !== el) || (alarm !== ea) || (fails !== ef)) begin
            bad++;
            $display("FAIL %s: got state=%b lock=%b alarm=%b fails=%0d, want state=%b lock=%b alarm=%b fails=%0d",
                     name, st, lock, alarm, fails, es, el, ea, ef);
        end
    endtask

    // Apply inputs at the falling edge, then look #1 after the rising edge.
    task automatic step(input logic e, input logic [3:0] d, input logic p, input logic r);
        @(negedge clk);
        enter = e; digit = d; prog = p; relock = r;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d, input logic p);
        step(1'b1, d, p, 1'b0);
        step(1'b0, 4'h0, p, 1'b0);
    endtask

    task automatic async_reset(input string name);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk(name, 2'b00, 2'd0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0; enter = 1'b0; digit = 4'h0; prog = 1'b0; relock = 1'b0;

        // Basic open with the default code D,7,9
        add(1, 4'hD, 0, 0, 2'b00, 2'd0);
        add(0, 4'h0, 0, 0, 2'b00, 2'd0);
        add(1, 4'h7, 0, 0, 2'b00, 2'd0);
        add(0, 4'h0, 0, 0, 2'b00, 2'd0);
        add(1, 4'h9, 0, 0, 2'b01, 2'd0);
        add(0, 4'h0, 0, 1, 2'b00, 2'd0);
        // Wrong middle digit: no early reject, Fails=1 after the third
        add(1, 4'hD, 0, 0, 2'b00, 2'd0);
        add(0, 4'h0, 0, 0, 2'b00, 2'd0);
        add(1, 4'h0, 0, 0, 2'b00, 2'd0);
        add(0, 4'h0, 0, 0, 2'b00, 2'd0);
        add(1, 4'h9, 0, 0, 2'b00, 2'd1);
        add(0, 4'h0, 0, 0, 2'b00, 2'd1);
        // Held Enter for 10 cycles with D counts once; then 7,9 opens
        for (int i = 0; i < 10; i++) add(1, 4'hD, 0, 0, 2'b00, 2'd1);
        add(0, 4'h0, 0, 0, 2'b00, 2'd1);
        add(1, 4'h7, 0, 0, 2'b00, 2'd1);
        add(0, 4'h0, 0, 0, 2'b00, 2'd1);
        add(1, 4'h9, 0, 0, 2'b01, 2'd0);
        add(0, 4'h0, 0, 0, 2'b01, 2'd0);
        // Program 1,2,3
        add(0, 4'h0, 1, 0, 2'b10, 2'd0);
        add(1, 4'h1, 1, 0, 2'b10, 2'd0);
        add(0, 4'h0, 1, 0, 2'b10, 2'd0);
        add(1, 4'h2, 1, 0, 2'b10, 2'd0);
        add(0, 4'h0, 1, 0, 2'b10, 2'd0);
        add(1, 4'h3, 1, 0, 2'b00, 2'd0);
        add(0, 4'h0, 0, 0, 2'b00, 2'd0);
        // Old code now fails, new code opens
        add(1, 4'hD, 0, 0, 2'b00, 2'd0);
        add(0, 4'h0, 0, 0, 2'b00, 2'd0);
        add(1, 4'h7, 0, 0, 2'b00, 2'd0);
        add(0, 4'h0, 0, 0, 2'b00, 2'd0);
        add(1, 4'h9, 0, 0, 2'b00, 2'd1);
        add(0, 4'h0, 0, 0, 2'b00, 2'd1);
        add(1, 4'h1, 0, 0, 2'b00, 2'd1);
        add(0, 4'h0, 0, 0, 2'b00, 2'd1);
        add(1, 4'h2, 0, 0, 2'b00, 2'd1);
        add(0, 4'h0, 0, 0, 2'b00, 2'd1);
        add(1, 4'h3, 0, 0, 2'b01, 2'd0);
        add(0, 4'h0, 0, 0, 2'b01, 2'd0);
        // Program dropped after two digits: back to OPEN, code kept
        add(0, 4'h0, 1, 0, 2'b10, 2'd0);
        add(1, 4'h4, 1, 0, 2'b10, 2'd0);
        add(0, 4'h0, 1, 0, 2'b10, 2'd0);
        add(1, 4'h5, 1, 0, 2'b10, 2'd0);
        add(0, 4'h0, 1, 0, 2'b10, 2'd0);
        add(0, 4'h0, 0, 0, 2'b01, 2'd0);
        add(0, 4'h0, 0, 1, 2'b00, 2'd0);
        add(1, 4'h1, 0, 0, 2'b00, 2'd0);
        add(0, 4'h0, 0, 0, 2'b00, 2'd0);
        add(1, 4'h2, 0, 0, 2'b00, 2'd0);
        add(0, 4'h0, 0, 0, 2'b00, 2'd0);
        add(1, 4'h3, 0, 0, 2'b01, 2'd0);
        // Relock beats Program in OPEN
        add(0, 4'h0, 1, 1, 2'b00, 2'd0);
        add(1, 4'h1, 0, 0, 2'b00, 2'd0);
        add(0, 4'h0, 0, 0, 2'b00, 2'd0);
        add(1, 4'h2, 0, 0, 2'b00, 2'd0);
        add(0, 4'h0, 0, 0, 2'b00, 2'd0);
        add(1, 4'h3, 0, 0, 2'b01, 2'd0);
        // Relock beats a press in PROG, code unchanged
        add(0, 4'h0, 1, 0, 2'b10, 2'd0);
        add(1, 4'h7, 1, 1, 2'b00, 2'd0);
        add(0, 4'h0, 0, 0, 2'b00, 2'd0);
        add(1, 4'h1, 0, 0, 2'b00, 2'd0);
        add(0, 4'h0, 0, 0, 2'b00, 2'd0);
        add(1, 4'h2, 0, 0, 2'b00, 2'd0);
        add(0, 4'h0, 0, 0, 2'b00, 2'd0);
        add(1, 4'h3, 0, 0, 2'b01, 2'd0);
        add(0, 4'h0, 0, 1, 2'b00, 2'd0);

        // Reset state, checked while reset is still held
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", 2'b00, 2'd0);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].e, vecs[i].d, vecs[i].p, vecs[i].r);
            chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].fl);
        end

        // Lockout: three wrong entries, current code is 1,2,3
        for (int a = 0; a < 2; a++) begin
            press(4'h0, 1'b0); press(4'h0, 1'b0); press(4'h0, 1'b0);
            chk($sformatf("wrong%0d", a + 1), 2'b00, 2'(a + 1));
        end
        press(4'h0, 1'b0); press(4'h0, 1'b0);
        step(1'b1, 4'h0, 1'b0, 1'b0);
        chk("lockout_enter", 2'b11, 2'd3);
        // Presses, Program and Relock all ignored; a rising Enter lands on the exit edge
        for (int j = 1; j <= 16; j++) begin
            step((j % 2) == 0, 4'h1, 1'b1, 1'b1);
            if (j < 16) chk($sformatf("lockout_c%0d", j), 2'b11, 2'd3);
            else        chk("lockout_exit", 2'b00, 2'd0);
        end
        step(1'b0, 4'h0, 1'b0, 1'b0);
        chk("post_lockout_idle", 2'b00, 2'd0);
        press(4'h1, 1'b0); press(4'h2, 1'b0);
        step(1'b1, 4'h3, 1'b0, 1'b0);
        chk("post_lockout_open", 2'b01, 2'd0);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        chk("post_lockout_relock", 2'b00, 2'd0);

        // Async reset mid-lockout
        for (int a = 0; a < 3; a++) begin
            press(4'h0, 1'b0); press(4'h0, 1'b0); press(4'h0, 1'b0);
        end
        chk("lockout_again", 2'b11, 2'd3);
        step(1'b0, 4'h0, 1'b0, 1'b0);
        async_reset("async_rst_lockout");

        // Code reverted to D,7,9
        press(4'hD, 1'b0); press(4'h7, 1'b0);
        step(1'b1, 4'h9, 1'b0, 1'b0);
        chk("reverted_code_open", 2'b01, 2'd0);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        chk("prog_again", 2'b10, 2'd0);
        press(4'h1, 1'b1); press(4'h2, 1'b1);
        async_reset("async_rst_prog");
        step(1'b0, 4'h0, 1'b0, 1'b0);
        chk("after_rst_idle", 2'b00, 2'd0);
        press(4'hD, 1'b0); press(4'h7, 1'b0);
        step(1'b1, 4'h9, 1'b0, 1'b0);
        chk("default_code_kept", 2'b01, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/combination_lock_param.md
Name: combination_lock_param

Overview:
- Parametrised successor to the lab combination lock FSM.
- Accepts a NUM_DIGITS-long code, one DIGIT_W-bit digit per Enter press.
- Adds edge-detected entry, deferred (non-revealing) mismatch checking, a failed-attempt counter with timed lockout, and re-programming of the code while open.
- Sits between the board switches/buttons (already debounced and synchronised upstream) and the LED/lock outputs.

Parameters:
- DIGIT_W, 4, width of one code digit.
- NUM_DIGITS, 3, digits per combination (>=1).
- DEFAULT_CODE, 12'hD79, reset code; NUM_DIGITS*DIGIT_W bits; digit 0 is the most-significant field.
- MAX_FAILS, 3, consecutive wrong full entries that trigger lockout (>=1).
- LOCKOUT_CYCLES, 16, clock cycles spent in lockout (>=1).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- Enter  input  1  digit-entry button (level); one press = one rising edge.
- Digit  input  DIGIT_W  digit value sampled on a press.
- Program  input  1  level; request code programming while open.
- Relock  input  1  level; close the lock from OPEN.
- state  output  2  current state: LOCKED=00, OPEN=01, PROG=10, LOCKOUT=11.
- Lock  output  4  4'b1111 when state==OPEN or PROG, else 4'b0000.
- Alarm  output  1  high exactly while state==LOCKOUT.
- Fails  output  $clog2(MAX_FAILS+1)  consecutive failed-entry count.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - state=LOCKED, Lock=0, Alarm=0, Fails=0.
  - Digit index=0, mismatch flag=0, lockout timer=0, Enter history=0.
  - Code register=DEFAULT_CODE.
  - Reset mid-entry, mid-programming or mid-lockout aborts that activity immediately.
- Press detection:
  - press = Enter & ~Enter_q, where Enter_q is Enter registered each cycle.
  - A held Enter produces exactly one press.
  - Effects of a press are visible after the same edge at which Enter is first sampled high (one-cycle latency).
- LOCKED:
  - Each press compares Digit with code[idx]; a miss sets the mismatch flag; idx increments.
  - No early reject: all NUM_DIGITS digits are always collected.
  - On the press where idx==NUM_DIGITS-1, the attempt is evaluated:
    - No mismatch (flag and current digit clean): go to OPEN, Fails=0.
    - Otherwise, if Fails+1 < MAX_FAILS: Fails increments, stay in LOCKED.
    - Otherwise: Fails=MAX_FAILS, go to LOCKOUT, timer=LOCKOUT_CYCLES-1.
  - idx and the mismatch flag clear after every evaluation.
  - Program and Relock are ignored in LOCKED.
- OPEN:
  - Relock high goes to LOCKED (idx=0). Relock takes priority over Program.
  - Otherwise, Program high goes to PROG (idx=0).
  - Presses are ignored.
- PROG:
  - Each press writes Digit into a shadow register at field idx; idx increments.
  - On the NUM_DIGITS-th press the shadow is committed to the code register and the FSM goes to LOCKED.
  - Program dropping low before commit aborts to OPEN: code unchanged, shadow discarded.
  - Relock in PROG aborts to LOCKED with code unchanged; Relock takes priority over a simultaneous press.
- LOCKOUT:
  - Presses, Program and Relock are ignored; idx stays 0.
  - The timer decrements each cycle. The transition to LOCKED occurs on the edge where the timer is 0, clearing Fails.
  - state reads LOCKOUT for exactly LOCKOUT_CYCLES cycles.
  - A press arriving on the exit cycle is discarded.
- Enter_q updates in every state, so a button held across a state change does not generate a press in the new state.
- Widths: idx is $clog2(NUM_DIGITS) bits (minimum 1); the timer is $clog2(LOCKOUT_CYCLES) bits (minimum 1); no counter wraps.
- All outputs are driven from registers or decoded from the state register only. No combinational path runs from inputs to outputs.

Test Plan:
- Reset with defaults; press D, 7, 9 -> state=01 and Lock=4'b1111 one cycle after the third press; Fails=0.
- Press D, 0, 9 -> state stays 00 through all three presses; Fails=1 after the third; Lock=0 throughout.
- Three wrong 3-digit entries -> state=11 and Alarm=1 for exactly 16 cycles, then state=00, Fails=0; presses during lockout change nothing.
- Hold Enter high for 10 cycles with Digit=D -> idx advances by exactly 1.
- From OPEN: Program=1, press 1, 2, 3 -> state=00. Then D, 7, 9 fails (Fails=1) and 1, 2, 3 opens. Dropping Program after two digits -> state=01 and the old code is kept.
- Assert Reset_n low asynchronously mid-lockout and mid-programming -> outputs clear immediately with no clock edge; code reverts to 12'hD79.
